// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: block geometry, default frame pitch and
// the state encoding of the current-block fetch sequencer.
package me_pkg;

  localparam int PIXEL            = 8;
  localparam int CURR_ROWS        = 32;
  localparam int CURR_WORDS_ROW   = 16;
  localparam int STRIDE_WORDS_DEF = 960;

  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_FETCH_ENC     = 3'd1;
  localparam logic [2:0] ST_WAIT_COMB_ENC = 3'd2;
  localparam logic [2:0] ST_PRESENT_ENC   = 3'd3;
  localparam logic [2:0] ST_DONE_ENC      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_FETCH     = ST_FETCH_ENC,
    ST_WAIT_COMB = ST_WAIT_COMB_ENC,
    ST_PRESENT   = ST_PRESENT_ENC,
    ST_DONE      = ST_DONE_ENC
  } fetch_state_e;

endpackage

// File: rtl/curr_addr_gen.sv
// Current-block SRAM address generator: latched base plus an accumulated row
// offset plus a word counter, all modulo 2^ADDR_W.
module curr_addr_gen import me_pkg::*; #(
  parameter int ADDR_W       = 16,
  parameter int STRIDE_WORDS = STRIDE_WORDS_DEF,
  parameter int WORDS_ROW    = CURR_WORDS_ROW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              row_inc,
  input  logic              word_inc,
  input  logic [ADDR_W-1:0] base_in,
  output logic [ADDR_W-1:0] addr_next,
  output logic              last_word
);

  localparam int                WORD_W = $clog2(WORDS_ROW);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(STRIDE_WORDS);
  localparam logic [WORD_W-1:0] LAST_W = WORD_W'(WORDS_ROW - 1);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    word_d = word_q;
    if (load) begin
      base_d = base_in;
      off_d  = '0;
      word_d = '0;
    end else if (row_inc) begin
      off_d  = off_q + STRIDE;
      word_d = '0;
    end else if (word_inc) begin
      word_d = word_q + 1'b1;
    end
  end

  // Address of the word that will be issued next cycle, so the top can register it.
  assign addr_next = base_d + off_d + {{(ADDR_W - WORD_W){1'b0}}, word_d};
  assign last_word = (word_q == LAST_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      off_q  <= '0;
      word_q <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/current_block_fetch_ctrl.sv
// Sequences the load of one current block: 2-pixel SRAM word reads per row, then
// presents each combined 32-pixel row to the PE array over a valid/ready handshake.
module current_block_fetch_ctrl import me_pkg::*; #(
  parameter int ADDR_W       = 16,
  parameter int STRIDE_WORDS = STRIDE_WORDS_DEF,
  parameter int ROWS         = CURR_ROWS,
  parameter int WORDS_ROW    = CURR_WORDS_ROW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] blk_base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              in_curr_enable,
  input  logic              curr_ready_32,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [4:0]        row_idx,
  output logic              busy,
  output logic              done,
  output fetch_state_e      dbg_state
);

  // Handshake: a row transfers on a clock edge where row_valid & row_ready are both
  // high; row_valid and row_idx stay stable until then, and row_ready is ignored otherwise.

  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  fetch_state_e      state_q, state_d;
  logic [4:0]        row_q, row_d;
  logic              ag_load, ag_row_inc, ag_word_inc, ag_last_word;
  logic [ADDR_W-1:0] ag_addr_next;

  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              row_valid_q, row_valid_d;
  logic [4:0]        row_idx_q, row_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  curr_addr_gen #(
    .ADDR_W       (ADDR_W),
    .STRIDE_WORDS (STRIDE_WORDS),
    .WORDS_ROW    (WORDS_ROW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ag_load),
    .row_inc   (ag_row_inc),
    .word_inc  (ag_word_inc),
    .base_in   (blk_base_addr),
    .addr_next (ag_addr_next),
    .last_word (ag_last_word)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    ag_load     = 1'b0;
    ag_row_inc  = 1'b0;
    ag_word_inc = 1'b0;
    // abort outranks everything, including a start arriving in IDLE
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FETCH;
            row_d   = '0;
            ag_load = 1'b1;
          end
        end
        ST_FETCH: begin
          ag_word_inc = 1'b1;
          if (ag_last_word) state_d = ST_WAIT_COMB;
        end
        ST_WAIT_COMB: begin
          if (curr_ready_32) state_d = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (row_ready) begin
            if (row_q == ROW_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_FETCH;
              row_d      = row_q + 5'd1;
              ag_row_inc = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    mem_rd_en_d = (state_d == ST_FETCH);
    mem_addr_d  = mem_rd_en_d ? ag_addr_next : '0;
    row_valid_d = (state_d == ST_PRESENT);
    row_idx_d   = row_valid_d ? row_d : 5'd0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      row_valid_q <= 1'b0;
      row_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en      = mem_rd_en_q;
  assign in_curr_enable = mem_rd_en_q;
  assign mem_addr       = mem_addr_q;
  assign row_valid      = row_valid_q;
  assign row_idx        = row_idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_current_block_fetch_ctrl.sv
// Bench for current_block_fetch_ctrl with a 1-cycle SRAM model and a 2->32 pixel
// combiner model; table-driven block loads plus abort, start-collision and reset cases.
module tb_current_block_fetch_ctrl;
  import me_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [15:0]  blk_base_addr = '0;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic         in_curr_enable;
  logic         curr_ready_32;
  logic         row_valid;
  logic         row_ready = 1'b1;
  logic [4:0]   row_idx;
  logic         busy;
  logic         done;
  fetch_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0]  addr_q[$];
  logic [260:0] row_q[$];

  int          stall_row_v = -1;
  int          stall_n_v = 0;
  int          stall_cnt = 0;
  int          rd_count = 0;
  int          transfers = 0;
  logic [15:0] row1_addr = '0;
  logic        stalled = 1'b0;
  logic [255:0] held_bus = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  current_block_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .blk_base_addr  (blk_base_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .in_curr_enable (in_curr_enable),
    .curr_ready_32  (curr_ready_32),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .row_idx        (row_idx),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // ---------------- SRAM + combiner models ----------------
  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic [15:0]  rdata;
  logic         en_d1;
  logic [3:0]   comb_cnt;
  logic [255:0] comb_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata         <= '0;
      en_d1         <= 1'b0;
      comb_cnt      <= '0;
      comb_bus      <= '0;
      curr_ready_32 <= 1'b0;
    end else begin
      if (mem_rd_en) rdata <= mem_data(mem_addr);
      en_d1 <= in_curr_enable;
      if (en_d1) begin
        comb_bus[16*comb_cnt +: 16] <= rdata;
        comb_cnt <= comb_cnt + 4'd1;
        if (comb_cnt == 4'd15) curr_ready_32 <= 1'b1;
        else if (comb_cnt == 4'd0) curr_ready_32 <= 1'b0;
      end else begin
        comb_cnt <= '0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_in_curr_enable"}, 32'(in_curr_enable), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_row_valid"}, 32'(row_valid), 32'd0);
    chk({tag, "_row_idx"}, 32'(row_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic push_block(input logic [15:0] base);
    logic [15:0]  a;
    logic [255:0] row;
    row = '0;
    for (int r = 0; r < 32; r++) begin
      for (int w = 0; w < 16; w++) begin
        a = base + 16'(r * 960 + w);
        addr_q.push_back(a);
        row[16*w +: 16] = mem_data(a);
      end
      row_q.push_back({5'(r), row});
    end
  endtask

  // ---------------- monitor / row_ready driver / scoreboard ----------------
  logic [15:0]  exp_addr;
  logic [260:0] exp_row;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en || in_curr_enable)
        chk("enable_eq_rd_en", 32'(in_curr_enable), 32'(mem_rd_en));
      if (mem_rd_en) begin
        if (rd_count == 16) row1_addr = mem_addr;
        rd_count++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual=%0h expected=none", mem_addr);
        end else begin
          exp_addr = addr_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        end
      end
      if (row_valid) begin
        chk("no_read_while_presenting", 32'(mem_rd_en), 32'd0);
        if (stalled) chk("bus_stable_during_stall", 32'(comb_bus != held_bus), 32'd0);
      end
    end
    if (row_valid === 1'b1 && int'(row_idx) == stall_row_v && stall_cnt < stall_n_v) begin
      row_ready = 1'b0;
      stall_cnt++;
    end else begin
      row_ready = 1'b1;
    end
    stalled  = (row_valid === 1'b1) && !row_ready;
    held_bus = comb_bus;
    if (rst_n && row_valid === 1'b1 && row_ready) begin
      transfers++;
      checks++;
      if (row_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_row actual=%0d expected=none", row_idx);
      end else begin
        exp_row = row_q.pop_front();
        if ({row_idx, comb_bus} !== exp_row) begin
          errors++;
          $display("FAIL row_transfer actual=%0h expected=%0h", {row_idx, comb_bus}, exp_row);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_block(input logic [15:0] base, input int s_row, input int s_n,
                           input int poke_at, output int cycles);
    @(negedge clk);
    push_block(base);
    stall_row_v = s_row;
    stall_n_v = s_n;
    stall_cnt = 0;
    rd_count = 0;
    transfers = 0;
    blk_base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (done !== 1'b1 && cycles < 1500) begin
      if (cycles == poke_at) begin
        start = 1'b1;
        blk_base_addr = 16'h5555;
      end
      @(negedge clk);
      start = 1'b0;
      blk_base_addr = base;
      cycles++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_one_shot", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("rows_transferred", 32'(transfers), 32'd32);
    chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
    chk("row_queue_empty", 32'(row_q.size()), 32'd0);
    stall_row_v = -1;
  endtask

  typedef struct {
    logic [15:0] base;
    int          stall_row;
    int          stall_n;
    int          poke_at;
    int          exp_cycles;
    logic [15:0] exp_row1;
  } vec_t;

  vec_t vecs[9];

  // ---------------- test sequence ----------------
  initial begin
    int          cyc;
    int          n;
    int          done_cnt;
    logic [15:0] target;

    vecs[0] = '{16'h0100, -1, 0, -1, 609, 16'h04C0};
    vecs[1] = '{16'h0100,  3, 5, -1, 614, 16'h04C0};
    vecs[2] = '{16'hFF00, -1, 0, -1, 609, 16'h02C0};
    vecs[3] = '{16'h1234, 31, 3, -1, 612, 16'h15F4};
    vecs[4] = '{16'h0000,  0, 1, -1, 610, 16'h03C0};
    vecs[5] = '{16'h0A00, -1, 0, 300, 609, 16'h0DC0};
    vecs[6] = '{16'h0800, -1, 0, 19, 609, 16'h0BC0};
    for (int i = 7; i < 9; i++) begin
      vecs[i].base       = 16'($urandom_range(0, 65535));
      vecs[i].stall_row  = $urandom_range(0, 31);
      vecs[i].stall_n    = $urandom_range(0, 8);
      vecs[i].poke_at    = -1;
      vecs[i].exp_cycles = 609 + vecs[i].stall_n;
      vecs[i].exp_row1   = vecs[i].base + 16'd960;
    end

    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    chk("in_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    for (int i = 0; i < 9; i++) begin
      run_block(vecs[i].base, vecs[i].stall_row, vecs[i].stall_n, vecs[i].poke_at, cyc);
      chk($sformatf("block_cycles_%0d", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      chk($sformatf("row1_addr_%0d", i), 32'(row1_addr), 32'(vecs[i].exp_row1));
    end

    // Abort during FETCH of row 7, word 9
    @(negedge clk);
    push_block(16'h0400);
    blk_base_addr = 16'h0400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    target = 16'h0400 + 16'(7 * 960 + 9);
    n = 0;
    while (!(mem_rd_en === 1'b1 && mem_addr === target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("abort_target_reached", 32'(mem_addr), 32'(target));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_all_zero("after_abort");
    addr_q.delete();
    row_q.delete();
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    chk("no_done_no_busy_after_abort", 32'(done_cnt), 32'd0);
    run_block(16'h2000, -1, 0, -1, cyc);
    chk("reload_after_abort_cycles", 32'(cyc), 32'd609);

    // start and abort together in IDLE
    @(negedge clk);
    blk_base_addr = 16'h7777;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_all_zero("start_abort_same_cycle");
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy === 1'b1 || mem_rd_en === 1'b1) done_cnt++;
    end
    chk("idle_after_start_abort", 32'(done_cnt), 32'd0);

    // Asynchronous reset while a row is being presented
    @(negedge clk);
    push_block(16'h0300);
    stall_row_v = 2;
    stall_n_v = 1000;
    stall_cnt = 0;
    blk_base_addr = 16'h0300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(row_valid === 1'b1 && row_idx === 5'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("present_row2_reached", 32'(row_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    addr_q.delete();
    row_q.delete();
    stall_row_v = -1;
    rst_n = 1'b1;
    run_block(16'h0300, -1, 0, -1, cyc);
    chk("block_after_reset_cycles", 32'(cyc), 32'd609);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
